event_blinker: RTL and testbench
================================

Name: event_blinker

Overview:
- Output-side counterpart to the button debouncer. Turns single-cycle event pulses into LED blinks that a person can see.
- Each accepted event produces one Led-high window of ON_CYCLES, followed by an OFF_CYCLES gap.
- Events that arrive during a blink are queued in a saturating pending counter and replayed in order.
- Sits between the debounced button/event sources and the board LEDs.

Parameters:
- ON_CYCLES, 200, Led-high duration per event in clocks; must be >=1.
- OFF_CYCLES, 200, forced Led-low gap after each blink in clocks; 0 means no gap.
- QUEUE_W, 4, pending counter width; maximum queued events is 2^QUEUE_W-1.

Ports:
- Clk  in  1  system clock; all logic on its rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Pulse  in  1  event input, synchronous to Clk.
- Flush  in  1  synchronous clear of queue, overflow and current blink.
- Led  out  1  registered LED drive.
- Busy  out  1  high while in ON or GAP.
- Pending  out  QUEUE_W  queued events not yet started.
- Overflow  out  1  sticky; set when an event was dropped at saturation.

Behaviour:
- Interface: one clock (Clk); reset Rst_n is asynchronous, active-low.
- Reset values: Led=0, Busy=0, Pending=0, Overflow=0, state IDLE, timer 0, edge register 0.
- FSM states:
  - IDLE: Led=0. An event at edge k moves to ON and loads the timer with ON_CYCLES-1. Led is high from edge k onward (1-cycle latency).
  - ON: Led=1. Timer decrements each cycle. At timer==0:
    - if OFF_CYCLES>0, go to GAP and load OFF_CYCLES-1;
    - else, if Pending>0, stay in ON, reload the timer and decrement Pending;
    - else go to IDLE.
  - GAP: Led=0. At timer==0: if Pending>0, go to ON, reload, decrement Pending; else go to IDLE.
- Led is high for exactly ON_CYCLES consecutive cycles per event.
- Busy is registered and equals (state!=IDLE).
- Event during ON or GAP: Pending increments.
- Event on the same cycle as a dequeue: net Pending unchanged.
- Event while Pending==2^QUEUE_W-1 and not dequeuing: Pending holds and Overflow<=1. Overflow stays set until Flush or reset.
- In IDLE, Pending is always 0. An event in IDLE starts a blink directly and is never queued.
- Flush has priority over everything. Next cycle: state IDLE, Led=0, Busy=0, Pending=0, Overflow=0. A Pulse in the same cycle as Flush is discarded.
- Timer width is $clog2(max(ON_CYCLES,OFF_CYCLES)+1). The timer never wraps; it is only loaded from IDLE/ON/GAP transitions.
- Reset asserted mid-blink forces all outputs to their reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: EVENT_BLINKER_EDGE_DETECT_EN.
- Defined: an event is a rising edge of Pulse, i.e. Pulse=1 with a registered previous value of 0. A level held high counts once. Because the edge register resets to 0, Pulse high in the first cycle after reset counts as an event.
- Undefined: every cycle with Pulse=1 is an event. No edge register is instantiated.

Decomposition:
- Package event_blinker_pkg holds:
  - the state enum (IDLE, ON, GAP);
  - a timer-width function;
  - the PENDING_MAX derivation.
- One sub-module, blink_timer: loadable down-counter with load, load_value and done (count==0) outputs. It is used for both the ON and GAP phases.

Test Plan:
All cases use ON_CYCLES=4, OFF_CYCLES=2, QUEUE_W=2, macro undefined unless stated.
1. Single Pulse sampled at edge 10 -> Led=1 after edges 10..13, Led=0 after edges 14..15 (GAP), Busy=1 across 10..15, IDLE from 16, Pending=0 throughout.
2. Pulse high for edges 10,11,12 -> Pending goes to 1 then 2. Blinks start at edges 10, 16, 22 (each 4 cycles). Pending reads 0 after edge 22.
3. Pulse at edge 10, then 5 more pulses at edges 11-15 -> Pending saturates at 3, Overflow=1 from the 4th queued pulse. Exactly 4 blinks total; Overflow still 1 at the end.
4. Flush at edge 12 with Pending=2 -> after edge 12: Led=0, Busy=0, Pending=0, Overflow=0. A concurrent Pulse is ignored.
5. Rst_n driven low mid-GAP between edges -> Led, Busy, Pending and Overflow read 0 before the next edge. After release, a Pulse produces a normal 4-cycle blink.
6. Pending=1 and Pulse on the final GAP cycle -> next blink starts on that edge with Pending still 1. With EVENT_BLINKER_EDGE_DETECT_EN defined, Pulse held high for 20 cycles yields exactly one blink.

Source files
------------

// File: rtl/event_blinker_pkg.sv
// event_blinker_pkg
//   Shared types and elaboration-time helpers for the event blinker.
//   - state_t      : blinker FSM state encoding (IDLE / ON / GAP)
//   - timer_w()    : width of the phase down-counter for given ON/OFF lengths
//   - pending_max(): largest value the pending-event counter can hold
package event_blinker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  // The counter is loaded with at most max(on, off) - 1, so a width that can
  // represent max(on, off) is always sufficient.
  function automatic int timer_w(input int on_c, input int off_c);
    int m;
    m = (on_c > off_c) ? on_c : off_c;
    return $clog2(m + 1);
  endfunction

  function automatic int pending_max(input int qw);
    return (1 << qw) - 1;
  endfunction

endpackage

// File: rtl/event_blinker_blink_timer.sv
// blink_timer
//   Loadable down-counter timing one ON or GAP phase. Counts down by one per
//   clock and rests at zero; it never wraps.
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous active-low reset (count -> 0)
//     load       in   load load_value on the next edge (wins over counting)
//     load_value in   W  value to load
//     done       out  count == 0
module blink_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/event_blinker.sv
// event_blinker
//   Turns single-cycle event pulses into human-visible LED blinks. Each event
//   gives exactly ON_CYCLES of Led high followed by an OFF_CYCLES low gap.
//   Events arriving while a blink is in progress are counted in a saturating
//   pending counter and replayed back to back.
//   Optional build macro: EVENT_BLINKER_EDGE_DETECT_EN
//     defined   : an event is a rising edge of Pulse (level held high = 1 event)
//     undefined : every cycle with Pulse high is an event
//   Ports:
//     Clk        in   system clock, rising edge
//     Rst_n      in   asynchronous active-low reset
//     Pulse      in   event input, synchronous to Clk
//     Flush      in   synchronous clear of queue, overflow and current blink
//     Led        out  registered LED drive
//     Busy       out  registered, high while in ON or GAP
//     Pending    out  QUEUE_W queued events not yet started
//     Overflow   out  sticky, an event was dropped at saturation
//     dbg_state  out  2 current FSM state (state_t encoding)
module event_blinker
  import event_blinker_pkg::*;
#(
  parameter int ON_CYCLES  = 200,
  parameter int OFF_CYCLES = 200,
  parameter int QUEUE_W    = 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Pulse,
  input  logic               Flush,
  output logic               Led,
  output logic               Busy,
  output logic [QUEUE_W-1:0] Pending,
  output logic               Overflow,
  output logic [1:0]         dbg_state
);

  localparam int                 TW          = timer_w(ON_CYCLES, OFF_CYCLES);
  localparam logic [TW-1:0]      ON_LOAD     = TW'(ON_CYCLES - 1);
  localparam bit                 HAS_GAP     = (OFF_CYCLES > 0);
  localparam logic [TW-1:0]      OFF_LOAD    = HAS_GAP ? TW'(OFF_CYCLES - 1) : '0;
  localparam logic [QUEUE_W-1:0] PENDING_MAX = QUEUE_W'(pending_max(QUEUE_W));

  state_t             state_q, state_d;
  logic               led_q, led_d;
  logic               busy_q, busy_d;
  logic [QUEUE_W-1:0] pending_q, pending_d;
  logic               overflow_q, overflow_d;

  logic               evt;
  logic               tmr_load;
  logic [TW-1:0]      tmr_val;
  logic               tmr_done;
  logic               deq;
  logic               queue_evt;
  logic               has_work;

`ifdef EVENT_BLINKER_EDGE_DETECT_EN
  logic pulse_prev_q, pulse_prev_d;

  always_comb begin
    pulse_prev_d = Pulse;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pulse_prev_q <= 1'b0;
    end else begin
      pulse_prev_q <= pulse_prev_d;
    end
  end

  assign evt = Pulse & ~pulse_prev_q;
`else
  assign evt = Pulse;
`endif

  blink_timer #(.W(TW)) u_timer (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .load       (tmr_load),
    .load_value (tmr_val),
    .done       (tmr_done)
  );

  // An event landing on the very cycle a phase ends counts as queued and is
  // consumed by that same transition, so the next blink starts seamlessly.
  assign has_work  = (pending_q != '0) || evt;
  assign queue_evt = evt && (state_q != IDLE);

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, timer control and dequeue request
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = ON_LOAD;
    deq      = 1'b0;
    if (Flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (evt) begin
            state_d  = ON;
            tmr_load = 1'b1;
          end
        end
        ON: begin
          if (tmr_done) begin
            if (HAS_GAP) begin
              state_d  = GAP;
              tmr_load = 1'b1;
              tmr_val  = OFF_LOAD;
            end else if (has_work) begin
              tmr_load = 1'b1;
              deq      = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        GAP: begin
          if (tmr_done) begin
            if (has_work) begin
              state_d  = ON;
              tmr_load = 1'b1;
              deq      = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / counter next values
  always_comb begin
    led_d      = (state_d == ON);
    busy_d     = (state_d != IDLE);
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (Flush) begin
      pending_d  = '0;
      overflow_d = 1'b0;
    end else begin
      case ({queue_evt, deq})
        2'b10: begin
          if (pending_q == PENDING_MAX) begin
            overflow_d = 1'b1;
          end else begin
            pending_d = pending_q + QUEUE_W'(1);
          end
        end
        2'b01:   pending_d = pending_q - QUEUE_W'(1);
        default: pending_d = pending_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      led_q      <= led_d;
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign Led       = led_q;
  assign Busy      = busy_q;
  assign Pending   = pending_q;
  assign Overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_event_blinker.sv
// tb_event_blinker
//   Directed test of event_blinker with ON_CYCLES=4, OFF_CYCLES=2, QUEUE_W=2.
//   Each vector is a set of per-edge strings ('_' is a readability separator);
//   character i gives the input applied at edge i and the outputs expected
//   just after it. Expected outputs are queued and checked by a monitor.
module tb_event_blinker;

  localparam int QW = 2;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Pulse = 1'b0;
  logic          Flush = 1'b0;
  logic          Led;
  logic          Busy;
  logic [QW-1:0] Pending;
  logic          Overflow;
  logic [1:0]    dbg_state;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  logic [4:0] exp_q[$];
  string      tag_q[$];

  event_blinker #(
    .ON_CYCLES  (4),
    .OFF_CYCLES (2),
    .QUEUE_W    (QW)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Pulse     (Pulse),
    .Flush     (Flush),
    .Led       (Led),
    .Busy      (Busy),
    .Pending   (Pending),
    .Overflow  (Overflow),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic byte at(input string s, input int i);
    if (i < s.len()) return s[i];
    return "0";
  endfunction

  function automatic logic [1:0] dig(input byte ch);
    return 2'(int'(ch) - 48);
  endfunction

  task automatic apply_reset();
    Rst_n = 1'b0;
    Pulse = 1'b0;
    Flush = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_outputs", {3'b0, Led, Busy, Pending, Overflow}, 8'h00);
    check("reset_state", {6'b0, dbg_state}, 8'h00);
    Rst_n = 1'b1;
    edge_n = 0;
  endtask

  // Driver: p=Pulse, f=Flush, l=Led, b=Busy, q=Pending digit, o=Overflow.
  // Missing / short strings mean all zeros.
  task automatic run_vec(input string tag, input string p, input string f,
                         input string l, input string b, input string q,
                         input string o);
    for (int i = 0; i < p.len(); i++) begin
      if (p[i] == "_") continue;
      Pulse = (at(p, i) == "1");
      Flush = (at(f, i) == "1");
      @(posedge Clk);
      #1;
      exp_q.push_back({at(l, i) == "1", at(b, i) == "1", dig(at(q, i)), at(o, i) == "1"});
      tag_q.push_back($sformatf("%s@edge%0d", tag, edge_n));
      edge_n++;
      Pulse = 1'b0;
      Flush = 1'b0;
    end
  endtask

  // Scoreboard monitor: one expected entry per edge, checked mid-cycle.
  initial begin
    logic [4:0] e;
    logic [1:0] es;
    string      t;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        es = e[4] ? 2'd1 : (e[3] ? 2'd2 : 2'd0);
        check({t, " led/busy/pend/ovf"}, {3'b0, Led, Busy, Pending, Overflow}, {3'b0, e});
        check({t, " state"}, {6'b0, dbg_state}, {6'b0, es});
      end
    end
  end

  initial begin
    // 1: single pulse at edge 10
    apply_reset();
    run_vec("t1_single",
      "00000_00000_10000_00000", "",
      "00000_00000_11110_00000",
      "00000_00000_11111_10000", "", "");

    // 2: pulses at 10,11,12 queue and replay
    apply_reset();
    run_vec("t2_queue",
      "00000_00000_11100_00000_00000_00000", "",
      "00000_00000_11110_01111_00111_10000",
      "00000_00000_11111_11111_11111_11100",
      "00000_00000_01222_21111_11000_00000", "");

    // 3: saturation, sticky overflow, then flush clears it
    apply_reset();
    run_vec("t3_overflow",
      "00000_00000_11111_10000_00000_00000_00000_00000_00000",
      "00000_00000_00000_00000_00000_00000_00000_00000_10000",
      "00000_00000_11110_01111_00111_10011_11000_00000_00000",
      "00000_00000_11111_11111_11111_11111_11110_00000_00000",
      "00000_00000_01233_32222_22111_11100_00000_00000_00000",
      "00000_00000_00001_11111_11111_11111_11111_11111_00000");

    // 4: flush at edge 12 with Pending=2 and a concurrent pulse, then recovery
    apply_reset();
    run_vec("t4_flush",
      "00000_00001_11100_10000_00000",
      "00000_00000_00100_00000_00000",
      "00000_00001_11000_11110_00000",
      "00000_00001_11000_11111_10000",
      "00000_00000_12000_00000_00000", "");

    // 5: asynchronous reset in the middle of GAP
    apply_reset();
    run_vec("t5_pre",
      "00000_00000_11000", "",
      "00000_00000_11110",
      "00000_00000_11111",
      "00000_00000_01111", "");
    @(negedge Clk);
    #1;
    Rst_n = 1'b0;
    #1;
    check("t5_async_reset_outputs", {3'b0, Led, Busy, Pending, Overflow}, 8'h00);
    check("t5_async_reset_state", {6'b0, dbg_state}, 8'h00);
    #1;
    Rst_n = 1'b1;
    edge_n = 0;
    run_vec("t5_post",
      "00100_00000", "",
      "00111_10000",
      "00111_11100", "", "");

    // 6: Pending=1 and a pulse on the final GAP cycle
    apply_reset();
    run_vec("t6_gap_end",
      "00000_00000_11000_01000_00000_00000", "",
      "00000_00000_11110_01111_00111_10000",
      "00000_00000_11111_11111_11111_11100",
      "00000_00000_01111_11111_11000_00000", "");

    // 7: Pulse held high for 20 cycles (edges 2..21)
    apply_reset();
`ifdef EVENT_BLINKER_EDGE_DETECT_EN
    run_vec("t7_held",
      "00111_11111_11111_11111_11000_00000_00000_00000_00000", "",
      "00111_10000_00000_00000_00000_00000_00000_00000_00000",
      "00111_11100_00000_00000_00000_00000_00000_00000_00000", "", "");
`else
    run_vec("t7_held",
      "00111_11111_11111_11111_11000_00000_00000_00000_00000", "",
      "00111_10011_11001_11100_11110_01111_00111_10011_11000",
      "00111_11111_11111_11111_11111_11111_11111_11111_11110",
      "00012_33333_33333_33333_33333_32222_22111_11100_00000",
      "00000_01111_11111_11111_11111_11111_11111_11111_11111");
`endif

    repeat (3) @(negedge Clk);
    #1;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
